// File: rtl/fetch_unit.sv
// Instruction fetch unit: single-outstanding memory requester feeding a
// 2-entry {pc, inst} queue toward the IF/ID register, with branch redirect.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pcsrc,
  input  logic [31:0] brpc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_pc,
  output logic [31:0] id_inst,
  output logic [1:0]  q_count
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] req_pc_q, req_pc_d;
  logic [31:0] pc_mem_q   [2];
  logic [31:0] inst_mem_q [2];
  logic        wr_ptr_q, wr_ptr_d;
  logic        rd_ptr_q, rd_ptr_d;
  logic [1:0]  count_q, count_d;

  logic        push, pop, issue;
  logic [1:0]  occ_next;
  logic [31:0] brpc_aligned;

  assign brpc_aligned = brpc & ~32'h0000_0003;

  // Queue handshakes; a redirect suppresses both push and pop.
  assign push     = !rst && !pcsrc && (state_q == S_WAIT) && imem_rvalid;
  assign id_valid = !rst && !pcsrc && (count_q != 2'd0);
  assign pop      = id_valid && id_ready;
  assign occ_next = count_q + {1'b0, push} - {1'b0, pop};

  // A new request may go out only if its response is guaranteed a queue slot.
  assign issue = !rst && !pcsrc && (state_q != S_DROP) &&
                 ((state_q == S_IDLE) || imem_rvalid) && (occ_next < 2'd2);

  // FSM: state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (issue) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          state_d = issue ? S_WAIT : S_IDLE;
        end else if (pcsrc) begin
          state_d = S_DROP;
        end
      end
      S_DROP: begin
        if (imem_rvalid) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    imem_req  = issue;
    imem_addr = fetch_pc_q;
  end

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    if (rst) begin
      fetch_pc_d = RESET_PC;
    end else if (pcsrc) begin
      fetch_pc_d = brpc_aligned;
    end else if (issue) begin
      fetch_pc_d = fetch_pc_q + 32'd4;
    end
  end

  assign req_pc_d = issue ? fetch_pc_q : req_pc_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q ^ push;
    rd_ptr_d = rd_ptr_q ^ pop;
    count_d  = occ_next;
    if (rst || pcsrc) begin
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
      count_d  = 2'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      count_q    <= 2'd0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  // Queue storage and request-PC tracking carry data only, so they are not reset.
  always_ff @(posedge clk) begin
    req_pc_q <= req_pc_d;
    if (push) begin
      pc_mem_q[wr_ptr_q]   <= req_pc_q;
      inst_mem_q[wr_ptr_q] <= imem_rdata;
    end
  end

  always_comb begin
    id_pc   = 32'd0;
    id_inst = 32'd0;
    if (id_valid) begin
      id_pc   = pc_mem_q[rd_ptr_q];
      id_inst = inst_mem_q[rd_ptr_q];
    end
  end

  assign q_count = rst ? 2'd0 : count_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: latency-configurable memory model plus an in-order
// instruction-stream model (sequential PCs, restarted on redirect or reset).
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pcsrc = 1'b0;
  logic [31:0] brpc = 32'd0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'd0;
  logic        id_valid;
  logic        id_ready = 1'b0;
  logic [31:0] id_pc;
  logic [31:0] id_inst;
  logic [1:0]  q_count;

  fetch_unit #(.RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst), .pcsrc(pcsrc), .brpc(brpc),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .id_valid(id_valid), .id_ready(id_ready),
    .id_pc(id_pc), .id_inst(id_inst), .q_count(q_count)
  );

  always #5 clk = ~clk;

  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          due = 0;
  int          lat_mode = 1;
  int          pops = 0;
  logic        pend = 1'b0;
  logic [31:0] pend_addr = 32'd0;
  logic [31:0] exp_pc = RESET_PC;
  logic        last_rv = 1'b0;

  function automatic logic [31:0] ifun(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  // One clock cycle: drive at the falling edge, observe 1 time unit later.
  task automatic step(input logic r, input logic pc, input logic [31:0] br,
                      input logic rdy, input logic frc);
    logic rv;
    @(negedge clk);
    rst = r; pcsrc = pc; brpc = br; id_ready = rdy;
    if (r) pend = 1'b0;
    rv = pend && (cyc >= due);
    imem_rvalid = rv || frc;
    imem_rdata  = rv ? ifun(pend_addr) : 32'hDEAD_BEEF;
    last_rv = rv;
    #1;
    checks++;
    if (q_count === 2'd3) begin
      errors++; $display("FAIL q_count_range: got %0d required <=2", q_count);
    end
    if (r || pc) begin
      checks++;
      if (imem_req !== 1'b0 || id_valid !== 1'b0) begin
        errors++;
        $display("FAIL quiet_on_rst_pcsrc: got req=%b valid=%b required 0/0", imem_req, id_valid);
      end
    end
    if (id_valid !== 1'b1) begin
      checks++;
      if (id_pc !== 32'd0 || id_inst !== 32'd0) begin
        errors++;
        $display("FAIL idle_outputs_zero: got pc=%h inst=%h required 0/0", id_pc, id_inst);
      end
    end
    if (id_valid === 1'b1 && rdy) begin
      checks++;
      if (id_pc !== exp_pc || id_inst !== ifun(exp_pc)) begin
        errors++;
        $display("FAIL stream_order: got pc=%h inst=%h required pc=%h inst=%h",
                 id_pc, id_inst, exp_pc, ifun(exp_pc));
      end
      exp_pc = exp_pc + 32'd4;
      pops++;
    end
    if (imem_req === 1'b1) begin
      checks++;
      if (pend && !rv) begin
        errors++; $display("FAIL single_outstanding: got second request at %h required none", imem_addr);
      end
    end
    if (r) exp_pc = RESET_PC;
    else if (pc) exp_pc = br & ~32'h3;
    if (rv) pend = 1'b0;
    if (imem_req === 1'b1) begin
      pend = 1'b1;
      pend_addr = imem_addr;
      due = cyc + ((lat_mode == 0) ? int'($urandom_range(1, 3)) : lat_mode);
    end
    cyc++;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 32'd0, 1'b1, 1'b0);
      checks++;
      if (imem_req !== 1'b0 || id_valid !== 1'b0 || id_pc !== 32'd0 ||
          id_inst !== 32'd0 || q_count !== 2'd0) begin
        errors++;
        $display("FAIL reset_outputs: got req=%b valid=%b pc=%h inst=%h cnt=%0d required all 0",
                 imem_req, id_valid, id_pc, id_inst, q_count);
      end
    end
    step(1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== RESET_PC) begin
      errors++;
      $display("FAIL reset_first_fetch: got req=%b addr=%h required 1/%h", imem_req, imem_addr, RESET_PC);
    end
  endtask

  task automatic test_stream();
    logic        req_s [5];
    logic [31:0] addr_s[5];
    logic        vld_s [5];
    logic [31:0] pc_s  [5];
    lat_mode = 1;
    step(1'b1, 1'b0, 32'd0, 1'b1, 1'b0);
    for (int k = 0; k < 5; k++) begin
      step(1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
      req_s[k] = imem_req; addr_s[k] = imem_addr; vld_s[k] = id_valid; pc_s[k] = id_pc;
    end
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (req_s[k] !== 1'b1 || addr_s[k] !== RESET_PC + 32'(4 * k)) begin
        errors++;
        $display("FAIL stream_addr[%0d]: got req=%b addr=%h required 1/%h", k, req_s[k], addr_s[k], RESET_PC + 32'(4 * k));
      end
    end
    checks++;
    if (vld_s[1] !== 1'b0) begin
      errors++; $display("FAIL stream_no_bypass: got valid=%b required 0", vld_s[1]);
    end
    for (int k = 2; k < 5; k++) begin
      checks++;
      if (vld_s[k] !== 1'b1 || pc_s[k] !== RESET_PC + 32'(4 * (k - 2))) begin
        errors++;
        $display("FAIL stream_id[%0d]: got valid=%b pc=%h required 1/%h", k, vld_s[k], pc_s[k], RESET_PC + 32'(4 * (k - 2)));
      end
    end
  endtask

  task automatic test_stall();
    for (int k = 0; k < 5; k++) begin
      step(1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
      if (k >= 1) begin
        checks++;
        if (imem_req !== 1'b0) begin
          errors++; $display("FAIL stall_req_drop[%0d]: got req=%b required 0", k, imem_req);
        end
      end
    end
    checks++;
    if (q_count !== 2'd2 || id_valid !== 1'b1) begin
      errors++; $display("FAIL stall_full: got cnt=%0d valid=%b required 2/1", q_count, id_valid);
    end
    for (int k = 0; k < 6; k++) step(1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
  endtask

  task automatic test_branch_drop();
    logic seen;
    lat_mode = 3;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      step(1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
      seen = imem_req;
    end
    if (!seen) begin
      errors++; $display("FAIL drop_find_issue: got no request required one within 10 cycles");
    end
    step(1'b0, 1'b1, 32'h0000_0103, 1'b1, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      step(1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
      if (last_rv) seen = 1'b1;
      checks++;
      if (imem_req !== 1'b0) begin
        errors++; $display("FAIL drop_no_issue: got req=%b addr=%h required 0", imem_req, imem_addr);
      end
    end
    checks++;
    if (!seen) begin
      errors++; $display("FAIL drop_timeout: got no late response required one");
    end
    step(1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0000_0100) begin
      errors++; $display("FAIL drop_redirect: got req=%b addr=%h required 1/00000100", imem_req, imem_addr);
    end
    for (int k = 0; k < 8; k++) step(1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
  endtask

  task automatic test_coincident();
    logic seen;
    lat_mode = 2;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      step(1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
      seen = imem_req;
    end
    if (!seen) begin
      errors++; $display("FAIL coinc_find_issue: got no request required one within 10 cycles");
    end
    step(1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 32'h0000_0200, 1'b1, 1'b0);
    step(1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0000_0200 || q_count !== 2'd0) begin
      errors++;
      $display("FAIL coinc_to_idle: got req=%b addr=%h cnt=%0d required 1/00000200/0", imem_req, imem_addr, q_count);
    end
    for (int k = 0; k < 6; k++) step(1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
  endtask

  task automatic test_flush_full();
    lat_mode = 1;
    for (int k = 0; k < 6; k++) step(1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
    checks++;
    if (q_count !== 2'd2) begin
      errors++; $display("FAIL flush_fill: got cnt=%0d required 2", q_count);
    end
    step(1'b0, 1'b1, 32'h0000_0300, 1'b1, 1'b1);
    checks++;
    if (id_valid !== 1'b0 || id_pc !== 32'd0) begin
      errors++; $display("FAIL flush_valid: got valid=%b pc=%h required 0/0", id_valid, id_pc);
    end
    step(1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
    checks++;
    if (q_count !== 2'd0 || id_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h0000_0300) begin
      errors++;
      $display("FAIL flush_after: got cnt=%0d valid=%b req=%b addr=%h required 0/0/1/00000300",
               q_count, id_valid, imem_req, imem_addr);
    end
    for (int k = 0; k < 6; k++) step(1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
  endtask

  task automatic test_wrap();
    lat_mode = 1;
    for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0);
    step(1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'hFFFF_FFFC) begin
      errors++; $display("FAIL wrap_target: got req=%b addr=%h required 1/fffffffc", imem_req, imem_addr);
    end
    step(1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0000_0000) begin
      errors++; $display("FAIL wrap_next: got req=%b addr=%h required 1/00000000", imem_req, imem_addr);
    end
    for (int k = 0; k < 5; k++) step(1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < 6; k++) step(1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
    checks++;
    if (q_count !== 2'd2) begin
      errors++; $display("FAIL rstmid_fill: got cnt=%0d required 2", q_count);
    end
    step(1'b1, 1'b0, 32'd0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
    checks++;
    if (q_count !== 2'd0 || id_valid !== 1'b0 || id_pc !== 32'd0 || id_inst !== 32'd0 ||
        imem_req !== 1'b1 || imem_addr !== RESET_PC) begin
      errors++;
      $display("FAIL rstmid_restart: got cnt=%0d valid=%b pc=%h req=%b addr=%h required 0/0/0/1/%h",
               q_count, id_valid, id_pc, imem_req, imem_addr, RESET_PC);
    end
    for (int k = 0; k < 5; k++) step(1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
  endtask

  task automatic test_random();
    int start_pops;
    lat_mode = 0;
    start_pops = pops;
    for (int k = 0; k < 800; k++) begin
      step(($urandom_range(0, 199) == 0), ($urandom_range(0, 99) < 4), $urandom,
           ($urandom_range(0, 3) != 0), 1'b0);
    end
    for (int k = 0; k < 12; k++) step(1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
    checks++;
    if (pops - start_pops < 100) begin
      errors++; $display("FAIL random_progress: got %0d deliveries required >=100", pops - start_pops);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_branch_drop();
    test_coincident();
    test_flush_full();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
